// File: rtl/io1bit_rx_sampler.sv
// rtl/io1bit_rx_sampler.sv - pad readback synchronizer, deglitch filter and turnaround gate
`timescale 1ns/1ps
module io1bit_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 4,
  parameter int TURN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p2f,
  input  logic       mode,
  input  logic       rx_en,
  output logic       rx_data,
  output logic       rx_valid,
  output logic       rise,
  output logic       fall,
  output logic [7:0] glitch_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TURN = 2'd1;
  localparam logic [1:0] RECV = 2'd2;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] FILT_LAST = 4'(FILTER_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             state_q, state_d;
  logic [3:0]             turn_q, turn_d;
  logic [3:0]             filt_q, filt_d;
  logic                   rx_data_q, rx_data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   s;
  logic                   go;

  assign s  = sync_q[SYNC_STAGES-1];
  assign go = ~mode & rx_en;

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    filt_d    = filt_q;
    rx_data_d = rx_data_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    glitch_d  = glitch_q;
    case (state_q)
      IDLE: begin
        filt_d = 4'd0;
        if (go) begin
          state_d = TURN;
          turn_d  = TURN_LOAD;
        end
      end
      TURN: begin
        if (!go) begin
          state_d = IDLE;
          turn_d  = 4'd0;
          filt_d  = 4'd0;
        end else if (turn_q == 4'd0) begin
          state_d   = RECV;
          rx_data_d = s;
          filt_d    = 4'd0;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      RECV: begin
        // abort outranks both a filter accept and a glitch
        if (!go) begin
          state_d = IDLE;
          turn_d  = 4'd0;
          filt_d  = 4'd0;
        end else if (s != rx_data_q) begin
          if (filt_q == FILT_LAST) begin
            rx_data_d = s;
            filt_d    = 4'd0;
            rise_d    = s;
            fall_d    = ~s;
          end else begin
            filt_d = filt_q + 4'd1;
          end
        end else if (filt_q != 4'd0) begin
          filt_d = 4'd0;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        turn_d  = 4'd0;
        filt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      turn_q    <= 4'd0;
      filt_q    <= 4'd0;
      rx_data_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], p2f};
      state_q   <= state_d;
      turn_q    <= turn_d;
      filt_q    <= filt_d;
      rx_data_q <= rx_data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      glitch_q  <= glitch_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = (state_q == RECV);
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_io1bit_rx_sampler.sv
// tb/tb_io1bit_rx_sampler.sv - self-checking bench for io1bit_rx_sampler
`timescale 1ns/1ps
module tb_io1bit_rx_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       p2f = 1'b1, mode = 1'b1, rx_en = 1'b1;
  logic       p2f_b = 1'b0, mode_b = 1'b1, rx_en_b = 1'b1;
  logic       rx_data, rx_valid, rise, fall;
  logic       rx_data_b, rx_valid_b, rise_b, fall_b;
  logic [7:0] glitch_cnt, glitch_cnt_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  io1bit_rx_sampler u_dut (
    .clk(clk), .rst_n(rst_n), .p2f(p2f), .mode(mode), .rx_en(rx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rise(rise), .fall(fall),
    .glitch_cnt(glitch_cnt)
  );

  io1bit_rx_sampler #(.SYNC_STAGES(3), .FILTER_CNT(1), .TURN_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .p2f(p2f_b), .mode(mode_b), .rx_en(rx_en_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rise(rise_b), .fall(fall_b),
    .glitch_cnt(glitch_cnt_b)
  );

  typedef struct {
    logic       b;
    logic       p2f, mode, en;
    logic       data, valid, rise, fall;
    logic [7:0] gl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic put(input logic b, input logic pv, input logic mv, input logic ev, input int n,
                     input logic d, input logic v, input logic r, input logic f, input int g);
    vec_t x;
    x.b = b; x.p2f = pv; x.mode = mv; x.en = ev;
    x.data = d; x.valid = v; x.rise = r; x.fall = f; x.gl = 8'(g);
    for (int i = 0; i < n; i++) tbl.push_back(x);
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    if (v.b) begin p2f_b = v.p2f; mode_b = v.mode; rx_en_b = v.en; end
    else     begin p2f = v.p2f; mode = v.mode; rx_en = v.en; end
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    if (e.b) begin
      chk("b_rx_data", rx_data_b, e.data);   chk("b_rx_valid", rx_valid_b, e.valid);
      chk("b_rise", rise_b, e.rise);         chk("b_fall", fall_b, e.fall);
      chk("b_glitch_cnt", glitch_cnt_b, e.gl);
    end else begin
      chk("rx_data", rx_data, e.data);       chk("rx_valid", rx_valid, e.valid);
      chk("rise", rise, e.rise);             chk("fall", fall, e.fall);
      chk("glitch_cnt", glitch_cnt, e.gl);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic v;
    int gp, gn;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rx_data", rx_data, 0);  chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rise", rise, 0);        chk("reset_fall", fall, 0);
    chk("reset_glitch_cnt", glitch_cnt, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // 1: driven pad for 20 cycles, then turnaround into RECV loading 1
    put(0, 1, 1, 1, 20, 0, 0, 0, 0, 0);
    put(0, 1, 0, 1, 3,  0, 0, 0, 0, 0);
    put(0, 1, 0, 1, 3,  1, 1, 0, 0, 0);
    // 2: settle to 0, then step 0->1 with 6-edge latency
    put(0, 0, 0, 1, 5,  1, 1, 0, 0, 0);
    put(0, 0, 0, 1, 1,  0, 1, 0, 1, 0);
    put(0, 0, 0, 1, 3,  0, 1, 0, 0, 0);
    put(0, 1, 0, 1, 5,  0, 1, 0, 0, 0);
    put(0, 1, 0, 1, 1,  1, 1, 1, 0, 0);
    put(0, 1, 0, 1, 3,  1, 1, 0, 0, 0);
    put(0, 0, 0, 1, 5,  1, 1, 0, 0, 0);
    put(0, 0, 0, 1, 1,  0, 1, 0, 1, 0);
    put(0, 0, 0, 1, 3,  0, 1, 0, 0, 0);
    apply();

    // 3: 2-cycle high glitches, counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      gp = (i < 255) ? i : 255;
      gn = (i + 1 < 255) ? i + 1 : 255;
      put(0, 1, 0, 1, 2, 0, 1, 0, 0, gp);
      put(0, 0, 0, 1, 2, 0, 1, 0, 0, gp);
      put(0, 0, 0, 1, 1, 0, 1, 0, 0, gn);
      apply();
    end

    // 4: abort on the accept edge suppresses fall, then re-entry loads 0
    put(0, 1, 0, 1, 5, 0, 1, 0, 0, 255);
    put(0, 1, 0, 1, 1, 1, 1, 1, 0, 255);
    put(0, 1, 0, 1, 3, 1, 1, 0, 0, 255);
    put(0, 0, 0, 1, 5, 1, 1, 0, 0, 255);
    put(0, 0, 1, 1, 2, 1, 0, 0, 0, 255);
    put(0, 0, 0, 1, 3, 1, 0, 0, 0, 255);
    put(0, 0, 0, 1, 3, 0, 1, 0, 0, 255);
    apply();

    // 5: reset mid-filter with glitch_cnt=7 and rx_data=1
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    put(0, 1, 0, 1, 3, 0, 0, 0, 0, 0);
    put(0, 1, 0, 1, 2, 1, 1, 0, 0, 0);
    apply();
    for (int i = 0; i < 7; i++) begin
      put(0, 0, 0, 1, 2, 1, 1, 0, 0, i);
      put(0, 1, 0, 1, 2, 1, 1, 0, 0, i);
      put(0, 1, 0, 1, 1, 1, 1, 0, 0, i + 1);
      apply();
    end
    put(0, 0, 0, 1, 3, 1, 1, 0, 0, 7);
    apply();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rx_data", rx_data, 0);   chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_rise", rise, 0);         chk("async_rst_fall", fall, 0);
    chk("async_rst_glitch_cnt", glitch_cnt, 0);
    #2 rst_n = 1'b1;
    put(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    put(0, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    apply();

    // 6: FILTER_CNT=1, SYNC_STAGES=3 instance follows toggles with 4-edge latency
    put(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    put(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    apply();
    v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v = ~v;
      put(1, v, 0, 1, 3, ~v, 1, 0, 0, 0);
      put(1, v, 0, 1, 1, v, 1, v, ~v, 0);
      put(1, v, 0, 1, 1, v, 1, 0, 0, 0);
      apply();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io1bit_rx_sampler.md
Name: io1bit_rx_sampler

Overview:
- Receive-side companion to the 1-bit bidirectional pad cell.
- Takes the raw pad readback (p2f) and the cell's direction control (mode); synchronizes, deglitches and edge-detects the pad level.
- Gates the result with a direction-turnaround state machine, so fabric logic sees only settled, filtered input while the pad is not being driven.
- One instance sits per pad, between the io cell's p2f output and fabric consumers.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on p2f; legal range 2..4.
- FILTER_CNT, 4: consecutive differing cycles needed to accept a new level; legal range 1..15.
- TURN_CYCLES, 3: idle cycles after the pad stops being driven before sampling starts; must be >= SYNC_STAGES and <= 15.

Ports:
- clk  input  1  Single clock for all logic.
- rst_n  input  1  Asynchronous active-low reset.
- p2f  input  1  Raw pad level from the io cell (asynchronous to clk).
- mode  input  1  Io cell direction; 1 = fabric drives pad (f2p), 0 = pad tri-stated. Synchronous to clk.
- rx_en  input  1  Receive enable; 0 forces IDLE.
- rx_data  output  1  Filtered pad level.
- rx_valid  output  1  1 while in RECV (rx_data tracks pad).
- rise  output  1  One-cycle pulse when rx_data goes 0->1 in RECV.
- fall  output  1  One-cycle pulse when rx_data goes 1->0 in RECV.
- glitch_cnt  output  8  Saturating count of rejected glitches.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. All flops reset on rst_n=0 regardless of clk.
- Reset values:
  - sync chain = 0, rx_data = 0, rx_valid = 0, rise = 0, fall = 0, glitch_cnt = 0.
  - State = IDLE; filter counter = 0; turn counter = 0.
- Synchronizer:
  - SYNC_STAGES-deep flop chain on p2f; the last stage is called s.
  - The chain always runs, in every state.
- States: IDLE, TURN, RECV, all registered. Exit conditions are evaluated on the sampled mode, rx_en and counters.
- IDLE:
  - rx_valid = 0; rx_data holds its last value; no pulses; filter counter held at 0.
  - If mode=0 and rx_en=1: go to TURN and load turn counter = TURN_CYCLES-1.
- TURN:
  - rx_valid = 0; turn counter decrements each cycle.
  - When the counter is 0 (and mode=0, rx_en=1): go to RECV, rx_data <= s, filter counter <= 0, no rise/fall.
  - So RECV is entered exactly TURN_CYCLES cycles after entering TURN.
- RECV:
  - rx_valid = 1.
  - If s != rx_data: filter counter increments. On the cycle the counter equals FILTER_CNT-1 with s still differing:
    - rx_data <= s;
    - counter <= 0;
    - the matching rise/fall is asserted for exactly the next cycle.
  - If s == rx_data and counter > 0: a glitch. Counter <= 0; glitch_cnt <= glitch_cnt+1, saturating at 255 (holds at 255).
  - FILTER_CNT=1: rx_data follows s one cycle later with no glitch rejection.
- Latency in RECV: a p2f change stable across sampling edges appears on rx_data SYNC_STAGES+FILTER_CNT clk edges after the first edge that samples it. With defaults, that is 6 edges.
- Abort: mode=1 or rx_en=0 in TURN or RECV forces IDLE on the next edge.
  - rx_valid is 0 from that edge.
  - Filter and turn counters are cleared.
  - A pending rise/fall is not produced.
  - rx_data holds.
- Simultaneous events:
  - Abort has priority over a filter update or TURN completion in the same cycle.
  - A filter update and a glitch cannot coincide (mutually exclusive conditions).
- rise and fall are never both 1, and are always 0 outside RECV.
- glitch_cnt is cleared only by reset; it does not clear on leaving RECV.
- Reset mid-operation: immediate return to the reset values above, with no pulse generated.

Test Plan:
1. Reset, mode=1, rx_en=1, p2f=1 for 20 cycles -> rx_valid=0, rx_data=0, no pulses. Drop mode to 0 -> rx_valid=1 exactly 3 cycles after entering TURN, and rx_data=1 loaded with no rise pulse.
2. In RECV with rx_data=0, step p2f 0->1 and hold -> rx_data=1 on the 6th edge after the first sampling edge. rise=1 for exactly one cycle; glitch_cnt unchanged.
3. In RECV with rx_data=0, drive p2f high for 2 cycles, then low -> rx_data stays 0, no pulses, glitch_cnt=1. Repeat 300 times -> glitch_cnt=255.
4. In RECV, step p2f 1->0, then assert mode=1 one cycle before the accept edge -> rx_valid=0 next cycle, no fall pulse, rx_data holds 1. Return mode=0 -> TURN, then RECV loads rx_data=0 with no pulse.
5. Assert rst_n=0 asynchronously mid-filter, between clk edges, with glitch_cnt=7 -> all outputs 0 immediately, state IDLE after release.
6. FILTER_CNT=1, SYNC_STAGES=3 build: toggle p2f every 5 cycles -> rx_data follows with 4-edge latency, one rise/fall per toggle, glitch_cnt stays 0.
